// File: rtl/instruction_fetch_queue_pkg.sv
// Shared pipeline-stage constants and the fetch-queue operation encoding.
package instruction_fetch_queue_pkg;

    // Default widths shared by every pipeline-stage register.
    localparam int   FQ_ADDR_WIDTH = 32;
    localparam int   FQ_DATA_WIDTH = 32;

    // Logic-level constants used by all pipeline stages.
    localparam logic FQ_HIGH = 1'b1;
    localparam logic FQ_LOW  = 1'b0;

    // What the queue does on a given edge, excluding flush and reset.
    typedef enum logic [1:0] {
        FQ_OP_IDLE = 2'b00,
        FQ_OP_POP  = 2'b01,
        FQ_OP_PUSH = 2'b10,
        FQ_OP_BOTH = 2'b11
    } fq_op_e;

    // Fold the qualified push/pop strobes into a single operation code.
    function automatic fq_op_e fq_decode_op(input logic push, input logic pop);
        fq_op_e op;
        case ({push, pop})
            2'b10:   op = FQ_OP_PUSH;
            2'b01:   op = FQ_OP_POP;
            2'b11:   op = FQ_OP_BOTH;
            default: op = FQ_OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry storage for the fetch queue: one synchronous write port, one
// asynchronous read port, no reset (contents are masked by the occupancy logic).
module fetch_queue_storage
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = FQ_ADDR_WIDTH + FQ_DATA_WIDTH,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the addressed entry when enabled; storage deliberately has no reset.
    always_ff @(posedge CLK) begin
        if (wr_en == FQ_HIGH) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// DEPTH-entry FIFO of {PC, instruction} pairs between fetch and decode.
// CLEAR_IN flushes synchronously and wins over push/pop; outputs are masked
// to zero whenever the queue is empty.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int   ADDR_WIDTH = FQ_ADDR_WIDTH,
    parameter int   DATA_WIDTH = FQ_DATA_WIDTH,
    parameter int   DEPTH      = 4,
    parameter logic HIGH       = FQ_HIGH,
    parameter logic LOW        = FQ_LOW
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CLEAR_IN,
    input  logic [ADDR_WIDTH-1:0]      PC_IN,
    input  logic [DATA_WIDTH-1:0]      INSTR_IN,
    input  logic                       VALID_IN,
    output logic                       READY_OUT,
    output logic [ADDR_WIDTH-1:0]      PC_OUT,
    output logic [DATA_WIDTH-1:0]      INSTR_OUT,
    output logic                       VALID_OUT,
    input  logic                       STALL_IN,
    output logic [$clog2(DEPTH):0]     COUNT_OUT
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  ready_r;
    logic                  valid_r;

    logic                  push_s;
    logic                  pop_s;
    fq_op_e                op_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [ENTRY_W-1:0]    wr_entry_s;
    logic [ENTRY_W-1:0]    head_entry_s;
    logic [ADDR_WIDTH-1:0] head_pc_s;
    logic [DATA_WIDTH-1:0] head_instr_s;

    // Handshake qualifiers: READY/VALID come from registers only, so no
    // combinational path exists from STALL_IN or VALID_IN to the outputs.
    assign push_s     = VALID_IN & ready_r & ~CLEAR_IN;
    assign pop_s      = valid_r & ~STALL_IN & ~CLEAR_IN;
    assign wr_entry_s = {PC_IN, INSTR_IN};

    fetch_queue_storage #(
        .DEPTH     (DEPTH),
        .WIDTH     (ENTRY_W),
        .ADDR_BITS (PTR_W)
    ) u_storage (
        .CLK     (CLK),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_entry_s),
        .rd_addr (rd_ptr_r),
        .rd_data (head_entry_s)
    );

    assign {head_pc_s, head_instr_s} = head_entry_s;

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        op_s        = fq_decode_op(push_s, pop_s);
        count_nxt_s = count_r;
        case (op_s)
            FQ_OP_PUSH: count_nxt_s = count_r + CNT_ONE;
            FQ_OP_POP:  count_nxt_s = count_r - CNT_ONE;
            FQ_OP_BOTH: count_nxt_s = count_r;
            FQ_OP_IDLE: count_nxt_s = count_r;
            default:    count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and status-flag state; reset and flush both empty the queue.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            ready_r  <= HIGH;
            valid_r  <= LOW;
        end else if (CLEAR_IN == HIGH) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            ready_r  <= HIGH;
            valid_r  <= LOW;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s < DEPTH_C) ? HIGH : LOW;
            valid_r <= (count_nxt_s != CNT_ZERO) ? HIGH : LOW;
        end
    end

    // Mask head data while empty so stale storage never reaches decode.
    always_comb begin
        if (valid_r == HIGH) begin
            PC_OUT    = head_pc_s;
            INSTR_OUT = head_instr_s;
        end else begin
            PC_OUT    = {ADDR_WIDTH{1'b0}};
            INSTR_OUT = {DATA_WIDTH{1'b0}};
        end
    end

    assign READY_OUT = ready_r;
    assign VALID_OUT = valid_r;
    assign COUNT_OUT = count_r;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed, table-driven bench for instruction_fetch_queue (DEPTH=4) plus a
// DEPTH=2 / DATA_WIDTH=16 instance exercised with a short hand-written sequence.
module tb_instruction_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST;

    // DEPTH=4 instance
    logic        clear_in, valid_in, stall_in;
    logic [31:0] pc_in, instr_in;
    logic        ready_out, valid_out;
    logic [31:0] pc_out, instr_out;
    logic [2:0]  count_out;

    // DEPTH=2, DATA_WIDTH=16 instance
    logic        clear2, valid2, stall2;
    logic [31:0] pc2;
    logic [15:0] instr2;
    logic        ready2_out, valid2_out;
    logic [31:0] pc2_out;
    logic [15:0] instr2_out;
    logic [1:0]  count2_out;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        stall;
        logic        clear;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    always #5 CLK = ~CLK;

    instruction_fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLEAR_IN  (clear_in),
        .PC_IN     (pc_in),
        .INSTR_IN  (instr_in),
        .VALID_IN  (valid_in),
        .READY_OUT (ready_out),
        .PC_OUT    (pc_out),
        .INSTR_OUT (instr_out),
        .VALID_OUT (valid_out),
        .STALL_IN  (stall_in),
        .COUNT_OUT (count_out)
    );

    instruction_fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (16),
        .DEPTH      (2)
    ) dut2 (
        .CLK       (CLK),
        .RST       (RST),
        .CLEAR_IN  (clear2),
        .PC_IN     (pc2),
        .INSTR_IN  (instr2),
        .VALID_IN  (valid2),
        .READY_OUT (ready2_out),
        .PC_OUT    (pc2_out),
        .INSTR_OUT (instr2_out),
        .VALID_OUT (valid2_out),
        .STALL_IN  (stall2),
        .COUNT_OUT (count2_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string tag, input logic er, input logic ev,
                          input logic [31:0] epc, input logic [31:0] ein, input logic [2:0] ec);
        check({tag, ".ready"}, 32'(ready_out), 32'(er));
        check({tag, ".valid"}, 32'(valid_out), 32'(ev));
        check({tag, ".pc"},    pc_out,         epc);
        check({tag, ".instr"}, instr_out,      ein);
        check({tag, ".count"}, 32'(count_out), 32'(ec));
    endtask

    task automatic check2(input string tag, input logic er, input logic ev,
                          input logic [31:0] epc, input logic [15:0] ein, input logic [1:0] ec);
        check({tag, ".ready"}, 32'(ready2_out), 32'(er));
        check({tag, ".valid"}, 32'(valid2_out), 32'(ev));
        check({tag, ".pc"},    pc2_out,         epc);
        check({tag, ".instr"}, 32'(instr2_out), 32'(ein));
        check({tag, ".count"}, 32'(count2_out), 32'(ec));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //            valid pc        instr     stall clr   ready valid e_pc      e_instr   cnt
        tbl[0]  = '{1'b1, 32'h0000, 32'h0013, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000, 32'h0013, 3'd1};
        tbl[1]  = '{1'b1, 32'h0004, 32'h0013, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000, 32'h0013, 3'd2};
        tbl[2]  = '{1'b1, 32'h0008, 32'h0013, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000, 32'h0013, 3'd3};
        tbl[3]  = '{1'b1, 32'h000C, 32'h0013, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000, 32'h0013, 3'd4};
        tbl[4]  = '{1'b1, 32'h0010, 32'h0013, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000, 32'h0013, 3'd4};
        // full + pop + offer: no bypass, 0x10 never enters
        tbl[5]  = '{1'b1, 32'h0010, 32'h0013, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0004, 32'h0013, 3'd3};
        tbl[6]  = '{1'b0, 32'h0000, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0008, 32'h0013, 3'd2};
        tbl[7]  = '{1'b0, 32'h0000, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000C, 32'h0013, 3'd1};
        tbl[8]  = '{1'b0, 32'h0000, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000, 32'h0000, 3'd0};
        tbl[9]  = '{1'b0, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000, 32'h0000, 3'd0};
        // three entries then flush with a simultaneous offer of 0x100
        tbl[10] = '{1'b1, 32'h0020, 32'h0011, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0020, 32'h0011, 3'd1};
        tbl[11] = '{1'b1, 32'h0024, 32'h0022, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0020, 32'h0011, 3'd2};
        tbl[12] = '{1'b1, 32'h0028, 32'h0033, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0020, 32'h0011, 3'd3};
        tbl[13] = '{1'b1, 32'h0100, 32'h0044, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000, 32'h0000, 3'd0};
        tbl[14] = '{1'b0, 32'h0000, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000, 32'h0000, 3'd0};

        RST      = 1'b1;
        clear_in = 1'b0; valid_in = 1'b0; stall_in = 1'b0; pc_in = 32'h0; instr_in = 32'h0;
        clear2   = 1'b0; valid2   = 1'b0; stall2   = 1'b0; pc2   = 32'h0; instr2   = 16'h0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check1("reset", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        check2("reset2", 1'b1, 1'b0, 32'h0, 16'h0, 2'd0);

        // Table-driven fill / drain / flush
        for (int i = 0; i < NVEC; i++) begin
            valid_in = tbl[i].valid;
            pc_in    = tbl[i].pc;
            instr_in = tbl[i].instr;
            stall_in = tbl[i].stall;
            clear_in = tbl[i].clear;
            step();
            check1($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_valid,
                   tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_cnt);
        end

        // Streaming push+pop for 20 cycles across pointer wrap
        stall_in = 1'b0;
        clear_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            valid_in = 1'b1;
            pc_in    = 32'h1000 + 32'(4 * k);
            instr_in = ~pc_in;
            step();
            check1($sformatf("stream%0d", k), 1'b1, 1'b1,
                   32'h1000 + 32'(4 * k), ~(32'h1000 + 32'(4 * k)), 3'd1);
        end
        valid_in = 1'b0;
        step();
        check1("stream_end", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

        // Asynchronous reset mid-cycle with two entries held
        stall_in = 1'b1;
        valid_in = 1'b1; pc_in = 32'h0500; instr_in = 32'h0055;
        step();
        pc_in = 32'h0504; instr_in = 32'h0056;
        step();
        check1("pre_rst", 1'b1, 1'b1, 32'h0500, 32'h0055, 3'd2);
        valid_in = 1'b0;
        #3;
        RST = 1'b1;
        #1;
        check1("async_rst", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        step();
        RST = 1'b0;
        valid_in = 1'b1; pc_in = 32'h0200; instr_in = 32'h0066;
        step();
        check1("post_rst_push", 1'b1, 1'b1, 32'h0200, 32'h0066, 3'd1);
        valid_in = 1'b0; stall_in = 1'b0;
        step();
        check1("post_rst_pop", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

        // DEPTH=2 / DATA_WIDTH=16 instance
        valid2 = 1'b1; stall2 = 1'b1; pc2 = 32'h0300; instr2 = 16'hBEEF;
        step();
        check2("d2_push1", 1'b1, 1'b1, 32'h0300, 16'hBEEF, 2'd1);
        pc2 = 32'h0304; instr2 = 16'hCAFE;
        step();
        check2("d2_push2", 1'b0, 1'b1, 32'h0300, 16'hBEEF, 2'd2);
        pc2 = 32'h0308; instr2 = 16'hF00D;
        step();
        check2("d2_full", 1'b0, 1'b1, 32'h0300, 16'hBEEF, 2'd2);
        valid2 = 1'b0; stall2 = 1'b0;
        step();
        check2("d2_pop1", 1'b1, 1'b1, 32'h0304, 16'hCAFE, 2'd1);
        step();
        check2("d2_pop2", 1'b1, 1'b0, 32'h0, 16'h0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Parametrised successor to the single-entry fetch-stage register: a DEPTH-entry FIFO of {PC, instruction} pairs between the fetch unit and decode. It decouples fetch from downstream stalls, gives synchronous flush on redirect, and reports occupancy. Stall/clear semantics match the existing pipeline-stage registers: CLEAR wins over everything and leaves zero/invalid contents.

## Interface
- ADDR_WIDTH, 32, PC width in bits
- DATA_WIDTH, 32, instruction word width in bits
- DEPTH, 4, number of entries; power of two, ≥ 2
- HIGH, 1'b1, logic-high constant
- LOW, 1'b0, logic-low constant
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous active-high reset
- CLEAR_IN  input  1  synchronous flush: empties queue this edge
- PC_IN  input  ADDR_WIDTH  PC of incoming instruction
- INSTR_IN  input  DATA_WIDTH  incoming instruction word
- VALID_IN  input  1  producer offers an entry this cycle
- READY_OUT  output  1  queue can accept an entry (not full)
- PC_OUT  output  ADDR_WIDTH  PC at head of queue
- INSTR_OUT  output  DATA_WIDTH  instruction at head of queue
- VALID_OUT  output  1  head entry is valid (queue not empty)
- STALL_IN  input  1  consumer stall: head is not popped this cycle
- COUNT_OUT  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Push = VALID_IN & READY_OUT & ~CLEAR_IN; pop = VALID_OUT & ~STALL_IN & ~CLEAR_IN.
- READY_OUT = (count < DEPTH); depends only on registered count, never on STALL_IN or VALID_IN.
- Full and consumer popping in the same cycle: READY_OUT still low, no push that cycle (no full-bypass).
- Push and pop in the same cycle (non-full, non-empty): count unchanged, both pointers advance.
- Empty: VALID_OUT = 0; PC_OUT and INSTR_OUT forced to 0 (masked), never stale data.
- Pointers: write and read pointers of $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count is a separate register of $clog2(DEPTH)+1 bits.
- CLEAR_IN high: at the edge, pointers and count go to 0, any simultaneous push/pop is discarded; storage contents need not be zeroed (outputs masked by empty).
- RST high: asynchronous; pointers, count to 0 immediately; outputs reflect empty. Reset mid-traffic drops all entries, no partial state.
- No push with VALID_IN low; data on PC_IN/INSTR_IN ignored when not pushed.

## Timing
- Reset values: READY_OUT = 1, VALID_OUT = 0, PC_OUT = 0, INSTR_OUT = 0, COUNT_OUT = 0.
- Latency: entry pushed at edge N is visible at head (VALID_OUT = 1) after edge N when queue was empty; no combinational input-to-output path.
- Pop at edge N: next entry (or empty) presented after edge N.
- COUNT_OUT, READY_OUT, VALID_OUT all update on the same edge; after CLEAR edge READY_OUT = 1, VALID_OUT = 0.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Shared header holds default ADDR_WIDTH, DATA_WIDTH, HIGH/LOW constants used by all pipeline stages.
- One natural sub-module: fetch_queue_storage — DEPTH x (ADDR_WIDTH+DATA_WIDTH) register array, one write port (synchronous, enable, address), one asynchronous read port; no reset on storage.
- Top level holds pointers, count, push/pop/clear logic and output masking.

## Test plan
- Reset then push PC=0x0000_0000..0x0000_000C, INSTR=0x0000_0013 with STALL_IN=1 -> COUNT_OUT 1,2,3,4; READY_OUT drops to 0 after 4th push; 5th offer (PC=0x10) not accepted.
- From full, release STALL_IN -> PC_OUT 0x0,0x4,0x8,0xC on successive cycles, then VALID_OUT=0, PC_OUT=0, COUNT_OUT=0.
- Continuous push+pop with STALL_IN=0 for 20 cycles, PC incrementing by 4 -> COUNT_OUT steady at 1, PC_OUT sequence in order across pointer wrap, no drops.
- Queue holding 3 entries, assert CLEAR_IN with VALID_IN=1, PC_IN=0x100 -> next cycle COUNT_OUT=0, VALID_OUT=0, READY_OUT=1; 0x100 not enqueued.
- Assert RST asynchronously mid-cycle with 2 entries -> VALID_OUT=0, COUNT_OUT=0 before next clock edge; first post-reset push PC=0x200 appears at head one cycle later.
- DEPTH=2, DATA_WIDTH=16 instance: full after 2 pushes, COUNT_OUT width 2 bits, ordering preserved.
